uart_word_tx: RTL and testbench
===============================

// Module: uart_word_tx
// PURPOSE
//  Serializes a 32-bit word as four 8N1 UART frames on one TX line, MSB byte first.
//  Sits between an upstream word source (e.g. FFT-result FIFO) and the board UART pin.
//  Each accepted word is acknowledged by a one-cycle wr_clk pulse, used as the FIFO pop.
//  With uart_en held high it streams words back-to-back.
// PARAMETERS
//  CLK_FREQ   100_000_000  system clock frequency in Hz
//  BAUD       115200       line rate in bit/s
//  BAUD_DIV   CLK_FREQ/BAUD (=868)  clocks per bit (localparam, derived)
// PORTS
//  clk      in   1   system clock, all logic on rising edge
//  rst_n    in   1   synchronous active-low reset
//  data     in   32  word to send; sampled only on the capture cycle
//  uart_en  in   1   level enable; high = transmit words continuously
//  wr_clk   out  1   one-cycle pulse marking word capture (upstream pop/ack)
//  tx       out  1   UART serial output, idle high
// BEHAVIOUR
//  - Clock: single domain clk. Reset: synchronous, active-low rst_n.
//  - Reset (rst_n=0 at an edge): tx=1, wr_clk=0, state=IDLE, counters=0. This applies mid-frame too:
//    the frame is abandoned, tx goes high at that edge, and no partial resume follows.
//  - States: IDLE -> START -> DATA -> STOP -> (START next byte | IDLE).
//  - IDLE: tx=1. At an edge with uart_en=1: shift_reg<=data, byte_idx<=0, state<=START,
//    tx<=0, and wr_clk<=1 for exactly the next cycle.
//  - Every bit holds tx for exactly BAUD_DIV clocks, timed by a baud counter reset on each bit.
//  - START: tx=0, 1 bit. DATA: 8 bits, LSB first, of the byte data[31-8*byte_idx -: 8].
//    STOP: tx=1, 1 bit.
//  - After a STOP with byte_idx<3: byte_idx++, go directly to START (no inter-byte gap).
//    After the STOP of byte 3: go to IDLE.
//  - Word period with uart_en continuously high: 40*BAUD_DIV + 1 clocks (one IDLE cycle).
//  - uart_en deasserted mid-word: the current word completes all 4 bytes; no new capture.
//  - uart_en is ignored outside IDLE. data changes after capture do not affect the word in flight.
//  - wr_clk is never high for more than 1 consecutive cycle. It is 0 in every cycle except
//    the cycle after capture.
// STRUCTURE
//  - Shared package uart_pkg: CLK_FREQ/BAUD defaults, state enum (IDLE/START/DATA/STOP),
//    BYTES_PER_WORD=4.
//  - Sub-module uart_baud_gen: counter 0..BAUD_DIV-1 with a clear input and a bit_done
//    tick output.
//  - Top level holds: FSM, 32-bit shift register, 3-bit bit counter, 2-bit byte counter.
// TESTING
//  1 Reset: hold rst_n=0 for 5 clocks mid-frame -> tx=1 and wr_clk=0 from the next edge;
//    no activity until uart_en is sampled.
//  2 Single word: data=32'hAA55AA55, uart_en high 1 clock.
//    -> one wr_clk pulse; tx sequence per byte is start0,
//       0,1,0,1,0,1,0,1 (0xAA), stop1, then the bytes 0x55, 0xAA, 0x55.
//       Each bit lasts 868 clocks (8.68 us at 10 ns).
//  3 Streaming: uart_en=1 for 1.7 ms (170000 clocks) at 100 MHz
//    -> exactly 5 wr_clk pulses at clocks 0, 34721, 69442, 104163, 138884;
//       the 5th word completes; tx=1 after it.
//  4 Enable drop mid-word: deassert uart_en during byte 1 -> bytes 1-3 still sent;
//    no further wr_clk.
//  5 Data stability: change data every clock after capture -> transmitted bytes equal
//    the captured word only.
//  6 Bit timing: measure every tx edge -> intervals are exact multiples of 868 clocks;
//    the line never goes low while in IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the word-serialising UART transmitter.
package uart_pkg;
  localparam int CLK_FREQ_DEF   = 100_000_000;
  localparam int BAUD_DEF       = 115200;
  localparam int BYTES_PER_WORD = 4;
  localparam int BITS_PER_BYTE  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;
endpackage

// File: rtl/uart_word_tx_if.sv
// Word-source handshake plus serial line of the UART word transmitter.
interface uart_word_tx_if;
  logic [31:0] data;
  logic        uart_en;
  logic        wr_clk;
  logic        tx;

  modport master (output data, output uart_en, input wr_clk, input tx);
  modport slave  (input data, input uart_en, output wr_clk, output tx);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..BAUD_DIV-1 and ticks on the last clock of each bit.
module uart_baud_gen #(
  parameter int BAUD_DIV = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  output logic o_bit_done
);
  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_bit_done = (r_cnt == LAST) && !i_clear;
endmodule

// File: rtl/uart_word_tx.sv
// Sends each captured 32-bit word as four back-to-back 8N1 frames, MSB byte first,
// pulsing wr_clk for one cycle on every capture so the source can pop its next word.
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = CLK_FREQ_DEF,
  parameter int BAUD     = BAUD_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_word_tx_if.slave  bus
);
  localparam int BAUD_DIV = CLK_FREQ / BAUD;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_shift;
  logic [2:0]  r_bit_cnt;
  logic [1:0]  r_byte_idx;
  logic        r_tx;
  logic        r_wr_clk;

  logic        w_bit_done;
  logic        w_clear;
  logic        w_capture;
  logic        w_last_bit;
  logic        w_last_byte;
  logic [7:0]  w_byte;
  logic [2:0]  w_bit_nxt;
  logic        w_tx_nxt;
  logic        w_wr_clk_nxt;

  // The timer is held cleared while idle so the start bit gets a full period.
  assign w_clear     = (r_state == IDLE);
  assign w_capture   = (r_state == IDLE) && bus.uart_en;
  assign w_last_bit  = (r_bit_cnt == 3'(BITS_PER_BYTE - 1));
  assign w_last_byte = (r_byte_idx == 2'(BYTES_PER_WORD - 1));
  assign w_byte      = r_shift[31:24];

  uart_baud_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_clear),
    .o_bit_done (w_bit_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (bus.uart_en) w_state_nxt = START;
      START:   if (w_bit_done) w_state_nxt = DATA;
      DATA:    if (w_bit_done && w_last_bit) w_state_nxt = STOP;
      STOP:    if (w_bit_done) w_state_nxt = w_last_byte ? IDLE : START;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Line level is decoded from the next state so tx leaves a flop, glitch-free.
  always_comb begin
    w_bit_nxt = r_bit_cnt;
    if (r_state == START) begin
      w_bit_nxt = '0;
    end else if (r_state == DATA && w_bit_done) begin
      w_bit_nxt = r_bit_cnt + 1'b1;
    end
    unique case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_byte[w_bit_nxt];
      default: w_tx_nxt = 1'b1;
    endcase
    w_wr_clk_nxt = w_capture;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx       <= 1'b1;
      r_wr_clk   <= 1'b0;
      r_bit_cnt  <= '0;
      r_byte_idx <= '0;
    end else begin
      r_tx      <= w_tx_nxt;
      r_wr_clk  <= w_wr_clk_nxt;
      r_bit_cnt <= w_bit_nxt;
      if (w_capture) begin
        r_byte_idx <= '0;
      end else if (r_state == STOP && w_bit_done && !w_last_byte) begin
        r_byte_idx <= r_byte_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_shift <= bus.data;
    end else if (r_state == STOP && w_bit_done) begin
      r_shift <= {r_shift[23:0], 8'h00};
    end
  end

  assign bus.tx     = r_tx;
  assign bus.wr_clk = r_wr_clk;
endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx at a scaled bit period of 8 clocks.
module tb_uart_word_tx;
  localparam int D        = 8;
  localparam int WORD_CYC = 40 * D;
  localparam int P        = WORD_CYC + 1;
  localparam int NS       = WORD_CYC + 4;

  typedef struct {
    logic [31:0] word;
    logic [7:0]  exp_b [4];
    int          keep_en;
    bit          scramble;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  uart_word_tx_if bus ();

  uart_word_tx #(
    .CLK_FREQ (80),
    .BAUD     (10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  logic s_tx [NS];
  logic s_wr [NS];
  vec_t tbl [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected line level k cycles after the capture edge.
  function automatic logic exp_tx(input logic [7:0] eb [4], input int k);
    int bn, f, b;
    if (k >= WORD_CYC) return 1'b1;
    bn = k / D;
    f  = bn / 10;
    b  = bn % 10;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return eb[f][b-1];
  endfunction

  task automatic run_word(input logic [31:0] w, input int keep, input bit scr);
    @(negedge clk);
    bus.data    = w;
    bus.uart_en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NS; k++) begin
      bus.uart_en = (k < keep);
      s_tx[k] = bus.tx;
      s_wr[k] = bus.wr_clk;
      if (scr) bus.data = $urandom;
      @(negedge clk);
    end
  endtask

  task automatic check_word(input vec_t v);
    int mism;
    int pulses;
    logic [9:0] fr;
    mism   = 0;
    pulses = 0;
    for (int k = 0; k < NS; k++) begin
      if (s_tx[k] !== exp_tx(v.exp_b, k)) mism++;
      if (s_wr[k] === 1'b1) pulses++;
    end
    check({v.name, "_wr_first"}, 32'(s_wr[0]), 32'd1);
    check({v.name, "_wr_pulses"}, 32'(pulses), 32'd1);
    check({v.name, "_wave_mismatch_cycles"}, 32'(mism), 32'd0);
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 10; i++) fr[i] = s_tx[(10 * f + i) * D + D / 2];
      check($sformatf("%s_frame%0d", v.name, f), 32'(fr), 32'({1'b1, v.exp_b[f], 1'b0}));
    end
  endtask

  initial begin
    int lows;
    int wrs;
    int mism;
    int k;
    int pt [$];
    logic [7:0] sb [4];

    tbl[0].word = 32'hAA55AA55; tbl[0].exp_b = '{8'hAA, 8'h55, 8'hAA, 8'h55};
    tbl[0].keep_en = 0; tbl[0].scramble = 1'b0; tbl[0].name = "aa55";
    tbl[1].word = 32'h12345678; tbl[1].exp_b = '{8'h12, 8'h34, 8'h56, 8'h78};
    tbl[1].keep_en = 0; tbl[1].scramble = 1'b1; tbl[1].name = "w12345678";
    tbl[2].word = 32'h00FF8001; tbl[2].exp_b = '{8'h00, 8'hFF, 8'h80, 8'h01};
    tbl[2].keep_en = 0; tbl[2].scramble = 1'b1; tbl[2].name = "w00ff8001";
    tbl[3].word = 32'hDEADBEEF; tbl[3].exp_b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    tbl[3].keep_en = 12 * D; tbl[3].scramble = 1'b1; tbl[3].name = "en_drop";

    rst_n       = 1'b0;
    bus.uart_en = 1'b0;
    bus.data    = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(bus.tx), 32'd1);
    check("reset_wr", 32'(bus.wr_clk), 32'd0);
    rst_n = 1'b1;

    // Reset in the middle of a frame while the line is low.
    @(negedge clk);
    bus.data    = 32'h00000000;
    bus.uart_en = 1'b1;
    @(negedge clk);
    bus.uart_en = 1'b0;
    repeat (15 * D) @(negedge clk);
    check("pre_reset_tx_low", 32'(bus.tx), 32'd0);
    rst_n = 1'b0;
    lows  = 0;
    wrs   = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.tx !== 1'b1) lows++;
      if (bus.wr_clk !== 1'b0) wrs++;
    end
    check("midframe_reset_tx_low_cycles", 32'(lows), 32'd0);
    check("midframe_reset_wr_cycles", 32'(wrs), 32'd0);
    rst_n = 1'b1;
    lows  = 0;
    wrs   = 0;
    for (int i = 0; i < 20 * D; i++) begin
      @(negedge clk);
      if (bus.tx !== 1'b1) lows++;
      if (bus.wr_clk !== 1'b0) wrs++;
    end
    check("post_reset_idle_tx_low_cycles", 32'(lows), 32'd0);
    check("post_reset_idle_wr_cycles", 32'(wrs), 32'd0);

    for (int v = 0; v < 4; v++) begin
      run_word(tbl[v].word, tbl[v].keep_en, tbl[v].scramble);
      check_word(tbl[v]);
    end

    // Streaming: five captures spaced one word period apart, then idle.
    sb = '{8'hC3, 8'hA5, 8'h0F, 8'h81};
    mism = 0;
    @(negedge clk);
    bus.data    = 32'hC3A50F81;
    bus.uart_en = 1'b1;
    for (int t = 0; t < 5 * P + 10; t++) begin
      if (t == 4 * P + 50) bus.uart_en = 1'b0;
      if (bus.wr_clk === 1'b1) pt.push_back(t);
      if (t == 0) begin
        if (bus.tx !== 1'b1) mism++;
      end else begin
        k = (t - 1) - P * (((t - 1) / P > 4) ? 4 : (t - 1) / P);
        if (bus.tx !== exp_tx(sb, k)) mism++;
      end
      @(negedge clk);
    end
    check("stream_pulse_count", 32'(pt.size()), 32'd5);
    for (int i = 0; i < pt.size() && i < 5; i++) begin
      check($sformatf("stream_pulse%0d_time", i), 32'(pt[i]), 32'(1 + i * P));
    end
    check("stream_wave_mismatch_cycles", 32'(mism), 32'd0);
    check("stream_final_tx", 32'(bus.tx), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
